// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled register pipeline with a valid flag per stage,
// a synchronous flush and a running count of occupied stages.
// Data stages load whatever is on d when the pipe advances; only the valid
// flags describe which stages hold real items.

module dff_pipe #(
    parameter int                 WIDTH   = 8,
    parameter int                 DEPTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    input  logic                         en,
    input  logic                         flush,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Data stages: hold unless advancing; flush leaves the data untouched.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (en && !flush) begin
            data_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = data_q[i];
            end
        end
    end

    // Valid flags: flush clears all, advance shifts d_valid in, otherwise hold.
    always_comb begin
        v_d = v_q;
        if (flush) begin
            v_d = {DEPTH{1'b0}};
        end else if (en) begin
            v_d[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                v_d[i] = v_q[i-1];
            end
        end else begin
            v_d = v_q;
        end
    end

    // Occupancy: one in from d_valid, one out from the last stage per advance.
    // When full, the exiting item always frees a slot, so the sum stays in range.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = {CW{1'b0}};
        end else if (en) begin
            count_d = count_q + CW'(d_valid) - CW'(v_q[DEPTH-1]);
        end else begin
            count_d = count_q;
        end
    end

    // State flops with asynchronous reset to the idle, empty pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
            v_q     <= {DEPTH{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = v_q[DEPTH-1];
    assign count   = count_q;
    assign busy    = (count_q != {CW{1'b0}});

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=0).
// Reference: a queue of in-flight items tagged with their age in advances,
// plus a DEPTH-long history of loaded data words for the q value.

module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
    logic             busy;

    int checks;
    int failures;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               age;
    } item_t;

    item_t            vq[$];
    logic [WIDTH-1:0] hist[$];

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .en(en),
        .flush(flush), .q(q), .q_valid(q_valid), .count(count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        vq.delete();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(8'h00);
    endtask

    task automatic model_edge(input logic [WIDTH-1:0] md, input logic mdv,
                              input logic men, input logic mfl);
        item_t it;
        if (mfl) begin
            vq.delete();
        end else if (men) begin
            for (int i = 0; i < vq.size(); i++) vq[i].age = vq[i].age + 1;
            if (vq.size() > 0 && vq[0].age == DEPTH) void'(vq.pop_front());
            if (mdv) begin
                it.data = md;
                it.age  = 0;
                vq.push_back(it);
            end
            hist.push_back(md);
            void'(hist.pop_front());
        end
    endtask

    function automatic logic exp_qv();
        return (vq.size() > 0) && (vq[0].age == DEPTH-1);
    endfunction

    // Drive at the falling edge, let one rising edge pass, update the model.
    task automatic cyc(input logic [WIDTH-1:0] cd, input logic cdv,
                       input logic cen, input logic cfl);
        d = cd; d_valid = cdv; en = cen; flush = cfl;
        @(posedge clk);
        model_edge(cd, cdv, cen, cfl);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; d = 8'h3C; d_valid = 1'b1; en = 1'b1; flush = 1'b0;
        model_reset();
        #100;
        @(negedge clk);
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_qv got=%b exp=0", q_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        cyc(8'hA5, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (q_valid !== (k == 4)) begin failures++; $display("FAIL single_qv edge=%0d got=%b exp=%b", k, q_valid, (k == 4)); end
            if (k == 4) begin
                checks++;
                if (q !== 8'hA5) begin failures++; $display("FAIL single_q got=%h exp=a5", q); end
            end
            checks++;
            if (count !== ((k <= 4) ? 3'd1 : 3'd0)) begin failures++; $display("FAIL single_count edge=%0d got=%0d", k, count); end
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] expq;
        expq = 8'h01;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) cyc(8'(k), 1'b1, 1'b1, 1'b0);
            else        cyc(8'h00, 1'b0, 1'b1, 1'b0);
            if (k >= 4 && k <= 8) begin
                checks++;
                if (count !== 3'd4) begin failures++; $display("FAIL stream_count k=%0d got=%0d exp=4", k, count); end
            end
            if (k >= 4 && k <= 11) begin
                checks++;
                if (q_valid !== 1'b1 || q !== expq) begin
                    failures++; $display("FAIL stream_q k=%0d got=%b/%h exp=1/%h", k, q_valid, q, expq);
                end
                expq = expq + 8'h01;
            end
        end
        checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stream_drain qv=%b busy=%b exp=0/0", q_valid, busy); end
    endtask

    task automatic test_stall();
        cyc(8'h11, 1'b1, 1'b1, 1'b0);
        cyc(8'h22, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(8'hFF, 1'b1, 1'b0, 1'b0);
            checks++;
            if (count !== 3'd2 || q_valid !== exp_qv() || q !== hist[0]) begin
                failures++; $display("FAIL stall_hold k=%0d count=%0d qv=%b q=%h exp=2/%b/%h", k, count, q_valid, q, exp_qv(), hist[0]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (q_valid === 1'b1 && q === 8'hFF) begin failures++; $display("FAIL stall_ff_valid k=%0d got=ff exp=not valid", k); end
            checks++;
            if (q_valid !== exp_qv() || (exp_qv() && q !== vq[0].data)) begin
                failures++; $display("FAIL stall_drain k=%0d qv=%b q=%h exp=%b", k, q_valid, q, exp_qv());
            end
        end
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] q_before;
        cyc(8'h31, 1'b1, 1'b1, 1'b0);
        cyc(8'h32, 1'b1, 1'b1, 1'b0);
        cyc(8'h33, 1'b1, 1'b1, 1'b0);
        q_before = hist[0];
        cyc(8'h99, 1'b1, 1'b0, 1'b1);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL flush_qv got=%b exp=0", q_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (q !== q_before) begin failures++; $display("FAIL flush_q got=%h exp=%h", q, q_before); end
        for (int k = 0; k < 5; k++) begin
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (q_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL flush_after k=%0d qv=%b count=%0d exp=0/0", k, q_valid, count); end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) cyc(8'h41 + 8'(k), 1'b1, 1'b1, 1'b0);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL areset_fill got=%0d exp=4", count); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (q !== 8'h00 || q_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL areset_immediate q=%h qv=%b count=%0d busy=%b exp=00/0/0/0", q, q_valid, count, busy);
        end
        d = 8'h77; d_valid = 1'b1; en = 1'b1; flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (q !== 8'h00 || q_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL areset_hold q=%h qv=%b count=%0d exp=00/0/0", q, q_valid, count);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (q_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL areset_stale k=%0d qv=%b count=%0d", k, q_valid, count); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] rd;
        logic rdv, ren, rfl;
        for (int k = 0; k < 10000; k++) begin
            rd  = 8'($urandom);
            rdv = ($urandom_range(0, 99) < 60);
            ren = ($urandom_range(0, 99) < 75);
            rfl = ($urandom_range(0, 99) < 3);
            cyc(rd, rdv, ren, rfl);
            checks++;
            if (q_valid !== exp_qv()) begin failures++; $display("FAIL rand_qv cyc=%0d got=%b exp=%b", k, q_valid, exp_qv()); end
            checks++;
            if (q !== hist[0]) begin failures++; $display("FAIL rand_q cyc=%0d got=%h exp=%h", k, q, hist[0]); end
            checks++;
            if (count !== CW'(vq.size())) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", k, count, vq.size()); end
            checks++;
            if (busy !== (vq.size() != 0)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", k, busy, (vq.size() != 0)); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 d  input  WIDTH  data into stage 0.
REQ-007 d_valid  input  1  marks d as a valid item.
REQ-008 en  input  1  advance enable; 0 = stall (hold all stages).
REQ-009 flush  input  1  synchronous invalidate of all stages.
REQ-010 q  output  WIDTH  data of stage DEPTH-1.
REQ-011 q_valid  output  1  valid flag of stage DEPTH-1.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid stages currently held.
REQ-013 busy  output  1  high when count != 0.

Function
REQ-014 Stage data[i] and flag v[i], i = 0..DEPTH-1, SHALL be flops; q = data[DEPTH-1], q_valid = v[DEPTH-1], driven directly from flops.
REQ-015 Rising edge, en=1, flush=0: data[0]<=d, v[0]<=d_valid, data[i]<=data[i-1], v[i]<=v[i-1] for i>=1.
REQ-016 Data stages SHALL load regardless of d_valid (plain DFF behaviour); only v[] carries validity.
REQ-017 Latency: an item presented with en=1 at edge N appears on q/q_valid after edge N+DEPTH-1 (visible after DEPTH edges with en held 1).
REQ-018 en=0, flush=0: all data[], v[], count hold; d and d_valid ignored.
REQ-019 flush=1 at an edge: all v[] <= 0, count <= 0, data[] unchanged; flush overrides en; d_valid on that edge dropped.
REQ-020 count update with en=1, flush=0: count <= count + d_valid - v[DEPTH-1]; simultaneous entry and exit leaves count unchanged.
REQ-021 count SHALL never exceed DEPTH nor underflow; when full (count=DEPTH) and en=1, v[DEPTH-1] exits as new item enters, so no overflow condition exists.
REQ-022 busy = (count != 0), combinational from count register.
REQ-023 DEPTH=1: block SHALL behave as a single enabled DFF with valid flag; count width 1.
REQ-024 X on d while d_valid=0 SHALL NOT propagate into v[] or count.

Reset
REQ-025 reset=1 SHALL immediately, without a clock edge, set all data[] to RST_VAL, all v[] to 0, count to 0; thus q=RST_VAL, q_valid=0, busy=0.
REQ-026 While reset=1 all inputs are ignored and state holds at reset values across clock edges.
REQ-027 Reset asserted mid-operation SHALL discard in-flight items; no item emerges after reset release unless re-entered.
REQ-028 First capture occurs on the first rising clk edge with reset=0.

Verification (WIDTH=8, DEPTH=4, RST_VAL=8'h00)
REQ-029 Reset 100 ns, then d=8'hA5,d_valid=1,en=1 for one edge, then d_valid=0 -> q=8'hA5,q_valid=1 exactly 4 edges after capture, for one cycle; count 1 during transit, 0 after.
REQ-030 Stream 8'h01..8'h08 valid, en=1 -> q sequence 01..08 consecutive, count saturates at 4 and stays 4 while streaming.
REQ-031 Load 2 items, hold en=0 for 5 cycles with d_valid=1, d=8'hFF -> q, q_valid, count unchanged; 8'hFF never appears as valid.
REQ-032 Fill 3 items, assert flush with en=0 and d_valid=1 -> next edge count=0, q_valid=0, busy=0, q unchanged.
REQ-033 Fill 4 items, assert reset asynchronously between edges -> q=8'h00, q_valid=0, count=0 before next edge; after release no stale item appears.
REQ-034 Randomised d/d_valid/en/flush for 10k cycles against reference queue model -> q_valid/q order, count and busy match every cycle.
